dram_stream_feeder: RTL

//  Upstream stage of the PE pipeline. Serves stream requests for compressed input

---
 rtl/scnn_stream_pkg.sv | 41 ++++
 rtl/stream_beat_packer.sv | 72 +++++++
 rtl/dram_stream_feeder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/scnn_stream_pkg.sv
// Shared types and sizing for the SCNN stream path.
// Holds the stream kind encoding, the PE beat payload, the feeder FSM states
// and a helper that sizes one beat from the remaining element count.
package scnn_stream_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned BURST     = 4;
  localparam int unsigned MAX_ELEMS = 64;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned WORD_W    = IDX_W + DATA_W;
  localparam int unsigned LEN_W     = $clog2(MAX_ELEMS + 1);
  localparam int unsigned CNT_W     = $clog2(BURST + 1);

  typedef enum logic {
    KIND_INPUT  = 1'b0,
    KIND_FILTER = 1'b1
  } stream_kind_e;

  typedef struct packed {
    logic [BURST-1:0][DATA_W-1:0] data;
    logic [BURST-1:0][IDX_W-1:0]  idx;
    logic [BURST-1:0]             mask;
    logic                         last;
    stream_kind_e                 kind;
  } stream_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EMIT,
    ST_DONE
  } feeder_state_e;

  // Lanes in the next beat: min(BURST, remaining).
  function automatic logic [CNT_W-1:0] beat_size(input logic [LEN_W-1:0] rem);
    if (rem >= LEN_W'(BURST)) return CNT_W'(BURST);
    return CNT_W'(rem);
  endfunction

endpackage

// File: rtl/stream_beat_packer.sv
// Collects DRAM read returns into the lanes of one output beat.
// Ports:
//   clk, rst    clock, async active-high reset
//   clear_i     zero all lanes/mask and rewind the lane pointer
//   cap_i       write rd_data_i into the lane under the pointer, then advance
//   rd_data_i   {idx, value} word from DRAM
//   data_o      lane values (lane0 = first captured)
//   idx_o       lane indices
//   mask_o      lane-valid bits
//   cnt_o       number of lanes captured since the last clear
module stream_beat_packer
  import scnn_stream_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         cap_i,
  input  logic [WORD_W-1:0]            rd_data_i,
  output logic [BURST-1:0][DATA_W-1:0] data_o,
  output logic [BURST-1:0][IDX_W-1:0]  idx_o,
  output logic [BURST-1:0]             mask_o,
  output logic [CNT_W-1:0]             cnt_o
);

  logic [BURST-1:0][DATA_W-1:0] data_q, data_d;
  logic [BURST-1:0][IDX_W-1:0]  idx_q, idx_d;
  logic [BURST-1:0]             mask_q, mask_d;
  logic [CNT_W-1:0]             ptr_q, ptr_d;

  // Lane write: clear wins over capture.
  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    mask_d = mask_q;
    ptr_d  = ptr_q;
    if (clear_i) begin
      data_d = '0;
      idx_d  = '0;
      mask_d = '0;
      ptr_d  = '0;
    end else if (cap_i) begin
      for (int unsigned k = 0; k < BURST; k++) begin
        if (ptr_q == CNT_W'(k)) begin
          data_d[k] = rd_data_i[DATA_W-1:0];
          idx_d[k]  = rd_data_i[WORD_W-1:DATA_W];
          mask_d[k] = 1'b1;
        end
      end
      ptr_d = ptr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
      mask_q <= '0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
      mask_q <= mask_d;
      ptr_q  <= ptr_d;
    end
  end

  assign data_o = data_q;
  assign idx_o  = idx_q;
  assign mask_o = mask_q;
  assign cnt_o  = ptr_q;

endmodule

// File: rtl/dram_stream_feeder.sv
// Serves PE stream requests (input activations or filter weights): reads
// {idx,value} words from DRAM, packs them into BURST-lane beats and pulses a
// per-kind finish strobe once the final beat has been accepted.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/kind/base/len   stream request, accepted only while req_ready
//   req_ready                 high only in IDLE
//   mem_rd_en/addr            DRAM read strobe and address
//   mem_rd_data               DRAM return, valid the cycle after mem_rd_en
//   out_valid/ready           beat handshake to the PE
//   out_kind/data/idx/mask    beat payload, lane0 = lowest address
//   out_last                  final beat of the stream
//   stream_input_finish       1-cycle pulse when an input stream completes
//   stream_filter_finish      1-cycle pulse when a filter stream completes
module dram_stream_feeder
  import scnn_stream_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_kind,
  input  logic [ADDR_W-1:0]       req_base,
  input  logic [LEN_W-1:0]        req_len,
  output logic                    req_ready,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic [WORD_W-1:0]       mem_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_kind,
  output logic [BURST*DATA_W-1:0] out_data,
  output logic [BURST*IDX_W-1:0]  out_idx,
  output logic [BURST-1:0]        out_mask,
  output logic                    out_last,
  output logic                    stream_input_finish,
  output logic                    stream_filter_finish
);

  feeder_state_e     state_q, state_d;
  stream_kind_e      kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;        // next read address
  logic [LEN_W-1:0]  rem_q, rem_d;          // elements not yet handed to the PE
  logic [CNT_W-1:0]  n_q, n_d;              // lanes in the beat being built
  logic [CNT_W-1:0]  issued_q, issued_d;    // reads issued for this beat
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic              rd_pend_q;             // a return lands this cycle
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              fin_in_q, fin_in_d;
  logic              fin_flt_q, fin_flt_d;
  logic              req_ready_q, req_ready_d;

  logic [LEN_W-1:0]  len_clamp_c;
  logic [LEN_W-1:0]  rem_after_c;
  logic              clear_c;
  logic              cap_c;
  logic              last_cap_c;

  logic [BURST-1:0][DATA_W-1:0] lane_data;
  logic [BURST-1:0][IDX_W-1:0]  lane_idx;
  logic [BURST-1:0]             lane_mask;
  logic [CNT_W-1:0]             lane_cnt;
  stream_beat_t                 beat_c;

  assign cap_c = rd_pend_q;

  stream_beat_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear_c),
    .cap_i     (cap_c),
    .rd_data_i (mem_rd_data),
    .data_o    (lane_data),
    .idx_o     (lane_idx),
    .mask_o    (lane_mask),
    .cnt_o     (lane_cnt)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    n_d           = n_q;
    issued_d      = issued_q;
    mem_rd_en_d   = 1'b0;
    mem_rd_addr_d = mem_rd_addr_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    fin_in_d      = 1'b0;
    fin_flt_d     = 1'b0;
    clear_c       = 1'b0;
    len_clamp_c   = (req_len > LEN_W'(MAX_ELEMS)) ? LEN_W'(MAX_ELEMS) : req_len;
    rem_after_c   = rem_q - LEN_W'(n_q);
    last_cap_c    = cap_c && (CNT_W'(lane_cnt + CNT_W'(1)) == n_q);

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          kind_d = stream_kind_e'(req_kind);
          rem_d  = len_clamp_c;
          if (len_clamp_c == '0) begin
            state_d = ST_DONE;
            if (stream_kind_e'(req_kind) == KIND_FILTER) fin_flt_d = 1'b1;
            else                                         fin_in_d  = 1'b1;
          end else begin
            // First read goes out in the cycle right after acceptance.
            state_d       = ST_FETCH;
            n_d           = beat_size(len_clamp_c);
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = req_base;
            addr_d        = req_base + ADDR_W'(1);
            issued_d      = CNT_W'(1);
            clear_c       = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        if (issued_q < n_q) begin
          mem_rd_en_d   = 1'b1;
          mem_rd_addr_d = addr_q;
          addr_d        = addr_q + ADDR_W'(1);
          issued_d      = issued_q + CNT_W'(1);
        end
        if (last_cap_c) begin
          state_d     = ST_EMIT;
          out_valid_d = 1'b1;
          out_last_d  = (rem_q == LEN_W'(n_q));
        end
      end

      ST_EMIT: begin
        // Beat is frozen until the PE takes it.
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rem_d       = rem_after_c;
          if (rem_after_c == '0) begin
            state_d = ST_DONE;
            if (kind_q == KIND_FILTER) fin_flt_d = 1'b1;
            else                       fin_in_d  = 1'b1;
          end else begin
            state_d       = ST_FETCH;
            n_d           = beat_size(rem_after_c);
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = addr_q;
            addr_d        = addr_q + ADDR_W'(1);
            issued_d      = CNT_W'(1);
            clear_c       = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      kind_q        <= KIND_INPUT;
      addr_q        <= '0;
      rem_q         <= '0;
      n_q           <= '0;
      issued_q      <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      rd_pend_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      fin_in_q      <= 1'b0;
      fin_flt_q     <= 1'b0;
      req_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      n_q           <= n_d;
      issued_q      <= issued_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      rd_pend_q     <= mem_rd_en_q;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      fin_in_q      <= fin_in_d;
      fin_flt_q     <= fin_flt_d;
      req_ready_q   <= req_ready_d;
    end
  end

  always_comb begin
    beat_c      = '0;
    beat_c.data = lane_data;
    beat_c.idx  = lane_idx;
    beat_c.mask = lane_mask;
    beat_c.last = out_last_q;
    beat_c.kind = kind_q;
  end

  assign req_ready            = req_ready_q;
  assign mem_rd_en            = mem_rd_en_q;
  assign mem_rd_addr          = mem_rd_addr_q;
  assign out_valid            = out_valid_q;
  assign out_kind             = beat_c.kind;
  assign out_data             = beat_c.data;
  assign out_idx              = beat_c.idx;
  assign out_mask             = beat_c.mask;
  assign out_last             = beat_c.last;
  assign stream_input_finish  = fin_in_q;
  assign stream_filter_finish = fin_flt_q;

endmodule
